rx_eyeq_responder: RTL

- PHY-side responder of the RX eye-quality 4-way handshake.
- Accepts rxeyeqreq with rxeyeqmode from the PCS/MAC controller, enables the AFE equalizer in the requested mode, waits a mode-dependent settle time, then averages 2^LOG2_NSAMP eye-margin samples.
- Returns the average on rxeyeq with rxeyeqdone, and holds both per protocol until the controller drops rxeyeqreq.

---
 rtl/rx_eyeq_pkg.sv | 60 ++++++
 rtl/rx_eyeq_if.sv | 20 ++
 rtl/rx_eyeq_accum.sv | 40 ++++
 rtl/rx_eyeq_responder.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/rx_eyeq_pkg.sv
// Shared types and helpers for the RX eye-quality responder.
// Mode encodings, power-down states, FSM states and mode decode functions.
package rx_eyeq_pkg;

  typedef enum logic [3:0] {
    EQM_STARTUP_NRZ_SDR   = 4'b0001,
    EQM_STARTUP_PAM4_SDR  = 4'b0010,
    EQM_STARTUP_ENRZ_SDR  = 4'b0011,
    EQM_STARTUP_NRZ_DDR   = 4'b0100,
    EQM_STARTUP_PAM4_DDR  = 4'b0101,
    EQM_STARTUP_ENRZ_DDR  = 4'b0110,
    EQM_BACKGROUND_NRZ    = 4'b1010,
    EQM_BACKGROUND_PAM4   = 4'b1011,
    EQM_BACKGROUND_ENRZ   = 4'b1100,
    EQM_WAKE_START_CDR    = 4'b1101
  } eyeqmode_t;

  typedef enum logic [1:0] {
    PD_NORMAL = 2'b00,
    PD_IDLE   = 2'b01,
    PD_COMA   = 2'b10,
    PD_SLEEP  = 2'b11
  } powerdown_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETTLE = 2'b01,
    ST_SAMPLE = 2'b10,
    ST_DONE   = 2'b11
  } eyeq_state_t;

  function automatic logic is_valid_mode(input logic [3:0] mode);
    logic ok;
    case (mode)
      EQM_STARTUP_NRZ_SDR, EQM_STARTUP_PAM4_SDR, EQM_STARTUP_ENRZ_SDR,
      EQM_STARTUP_NRZ_DDR, EQM_STARTUP_PAM4_DDR, EQM_STARTUP_ENRZ_DDR,
      EQM_BACKGROUND_NRZ, EQM_BACKGROUND_PAM4, EQM_BACKGROUND_ENRZ,
      EQM_WAKE_START_CDR: ok = 1'b1;
      default:            ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Settle lengths come from the instantiating module's parameters.
  function automatic int unsigned settle_cycles(input logic [3:0] mode,
                                                input int unsigned startup,
                                                input int unsigned bg,
                                                input int unsigned wake);
    int unsigned n;
    case (mode)
      EQM_STARTUP_NRZ_SDR, EQM_STARTUP_PAM4_SDR, EQM_STARTUP_ENRZ_SDR,
      EQM_STARTUP_NRZ_DDR, EQM_STARTUP_PAM4_DDR, EQM_STARTUP_ENRZ_DDR: n = startup;
      EQM_BACKGROUND_NRZ, EQM_BACKGROUND_PAM4, EQM_BACKGROUND_ENRZ:    n = bg;
      EQM_WAKE_START_CDR:                                              n = wake;
      default:                                                         n = 32'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/rx_eyeq_if.sv
// Controller-facing eye-quality handshake bundle (request, mode, power state, result).
interface rx_eyeq_if #(
  parameter int RES_W = 32
);
  logic [1:0]       rxpdwn;
  logic             rxeyeqreq;
  logic [3:0]       rxeyeqmode;
  logic             rxeyeqdone;
  logic [RES_W-1:0] rxeyeq;

  modport master (
    output rxpdwn, rxeyeqreq, rxeyeqmode,
    input  rxeyeqdone, rxeyeq
  );

  modport slave (
    input  rxpdwn, rxeyeqreq, rxeyeqmode,
    output rxeyeqdone, rxeyeq
  );
endinterface

// File: rtl/rx_eyeq_accum.sv
// Eye-margin sample accumulator: sums 2^LOG2_NSAMP valid samples and flags the last one.
// The average includes the sample presented in the cycle full_s is high.
module rx_eyeq_accum #(
  parameter int SMP_W      = 8,
  parameter int LOG2_NSAMP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             vld,
  input  logic [SMP_W-1:0] sample,
  output logic             full_s,
  output logic [SMP_W-1:0] avg_s
);
  localparam int SUM_W = SMP_W + LOG2_NSAMP;

  logic [SUM_W-1:0]      sum_r;
  logic [SUM_W-1:0]      sum_next_s;
  logic [LOG2_NSAMP-1:0] cnt_r;

  assign sum_next_s = sum_r + SUM_W'(sample);
  assign full_s     = en && vld && (cnt_r == {LOG2_NSAMP{1'b1}});
  assign avg_s      = SMP_W'(sum_next_s >> LOG2_NSAMP);

  // Running sum and sample count
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sum_r <= '0;
      cnt_r <= '0;
    end else if (en && vld) begin
      sum_r <= sum_next_s;
      cnt_r <= cnt_r + LOG2_NSAMP'(1);
    end else begin
      sum_r <= sum_r;
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/rx_eyeq_responder.sv
// PHY-side responder of the RX eye-quality 4-way handshake: settle the equalizer,
// average eye-margin samples, return the result and hold it until the request drops.
module rx_eyeq_responder
  import rx_eyeq_pkg::*;
#(
  parameter int RES_W          = 32,
  parameter int SMP_W          = 8,
  parameter int LOG2_NSAMP     = 4,
  parameter int SETTLE_STARTUP = 64,
  parameter int SETTLE_BG      = 16,
  parameter int SETTLE_WAKE    = 32,
  parameter int TIMEOUT        = 1024
) (
  input  logic             clk,
  input  logic             rst,
  rx_eyeq_if.slave         bus,
  input  logic [SMP_W-1:0] eye_sample,
  input  logic             eye_sample_vld,
  output logic             afe_eq_en,
  output logic [3:0]       afe_eq_mode,
  output logic             aborted,
  output logic             protocol_err
);
  localparam int MAX_A   = (SETTLE_STARTUP > SETTLE_BG) ? SETTLE_STARTUP : SETTLE_BG;
  localparam int MAX_B   = (SETTLE_WAKE > TIMEOUT) ? SETTLE_WAKE : TIMEOUT;
  localparam int MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  eyeq_state_t      state_r, state_s;
  logic             req_d_r;
  logic             done_r, done_s;
  logic [RES_W-1:0] res_r, res_s;
  logic             en_r, en_s;
  logic [3:0]       mode_r, mode_s;
  logic             abort_r, abort_s;
  logic             perr_r, perr_s;
  logic             chk_r, chk_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             acc_clr_s;
  logic             full_s;
  logic [SMP_W-1:0] avg_s;
  logic             req_rise_s;
  logic             pd_ok_s;

  assign req_rise_s = bus.rxeyeqreq && !req_d_r;
  assign pd_ok_s    = (bus.rxpdwn == PD_NORMAL);

  rx_eyeq_accum #(
    .SMP_W      (SMP_W),
    .LOG2_NSAMP (LOG2_NSAMP)
  ) u_accum (
    .clk    (clk),
    .rst    (rst),
    .clr    (acc_clr_s),
    .en     (state_r == ST_SAMPLE),
    .vld    (eye_sample_vld),
    .sample (eye_sample),
    .full_s (full_s),
    .avg_s  (avg_s)
  );

  // Next-state and next-output decode
  always_comb begin
    state_s   = state_r;
    done_s    = done_r;
    res_s     = res_r;
    en_s      = en_r;
    mode_s    = mode_r;
    abort_s   = abort_r;
    perr_s    = perr_r;
    chk_s     = chk_r;
    cnt_s     = cnt_r;
    acc_clr_s = 1'b0;

    // chk_r is set only while a validly captured mode is in use
    if (chk_r && (bus.rxeyeqmode != mode_r)) begin
      perr_s = 1'b1;
    end else begin
      perr_s = perr_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (req_rise_s && !pd_ok_s) begin
          perr_s = 1'b1;
        end else if (req_rise_s && !is_valid_mode(bus.rxeyeqmode)) begin
          state_s = ST_DONE;
          done_s  = 1'b1;
          res_s   = '0;
          abort_s = 1'b1;
          en_s    = 1'b0;
        end else if (req_rise_s) begin
          state_s = ST_SETTLE;
          mode_s  = bus.rxeyeqmode;
          en_s    = 1'b1;
          abort_s = 1'b0;
          chk_s   = 1'b1;
          cnt_s   = CNT_W'(settle_cycles(bus.rxeyeqmode, SETTLE_STARTUP, SETTLE_BG, SETTLE_WAKE));
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (!bus.rxeyeqreq) begin
          state_s = ST_IDLE;
          perr_s  = 1'b1;
          en_s    = 1'b0;
          chk_s   = 1'b0;
        end else if (!pd_ok_s) begin
          state_s = ST_DONE;
          done_s  = 1'b1;
          res_s   = '0;
          abort_s = 1'b1;
          en_s    = 1'b0;
        end else if (cnt_r == '0) begin
          state_s   = ST_SAMPLE;
          acc_clr_s = 1'b1;
        end else begin
          cnt_s = cnt_r - CNT_W'(1);
        end
      end
      ST_SAMPLE: begin
        if (!bus.rxeyeqreq) begin
          state_s = ST_IDLE;
          perr_s  = 1'b1;
          en_s    = 1'b0;
          chk_s   = 1'b0;
        end else if (!pd_ok_s) begin
          state_s = ST_DONE;
          done_s  = 1'b1;
          res_s   = '0;
          abort_s = 1'b1;
          en_s    = 1'b0;
        end else if (full_s) begin
          state_s = ST_DONE;
          done_s  = 1'b1;
          res_s   = RES_W'(avg_s);
          en_s    = 1'b0;
        end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
          state_s = ST_DONE;
          done_s  = 1'b1;
          res_s   = '0;
          abort_s = 1'b1;
          en_s    = 1'b0;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (!bus.rxeyeqreq) begin
          state_s = ST_IDLE;
          done_s  = 1'b0;
          chk_s   = 1'b0;
        end else begin
          done_s = 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
        done_s  = 1'b0;
        en_s    = 1'b0;
        chk_s   = 1'b0;
      end
    endcase
  end

  // State and registered output update
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      req_d_r <= 1'b0;
      done_r  <= 1'b0;
      res_r   <= '0;
      en_r    <= 1'b0;
      mode_r  <= 4'b0000;
      abort_r <= 1'b0;
      perr_r  <= 1'b0;
      chk_r   <= 1'b0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      req_d_r <= bus.rxeyeqreq;
      done_r  <= done_s;
      res_r   <= res_s;
      en_r    <= en_s;
      mode_r  <= mode_s;
      abort_r <= abort_s;
      perr_r  <= perr_s;
      chk_r   <= chk_s;
      cnt_r   <= cnt_s;
    end
  end

  assign bus.rxeyeqdone = done_r;
  assign bus.rxeyeq     = res_r;
  assign afe_eq_en      = en_r;
  assign afe_eq_mode    = mode_r;
  assign aborted        = abort_r;
  assign protocol_err   = perr_r;

endmodule
